// File: rtl/pwm_servo_array_if.sv
// pwm_servo_array_if: control/status bundle between the tracker FSM and the servo PWM block.
// Signals: en (run enable), dir (2 bits/channel command), load_pw (target per channel),
// servo (PWM pins), pw_out (width in effect), at_limit (width at MIN/MAX), frame_start (frame pulse).
interface pwm_servo_array_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 16
);
  logic                    en;
  logic [2*N_CH-1:0]       dir;
  logic [CNT_W*N_CH-1:0]   load_pw;
  logic [N_CH-1:0]         servo;
  logic [CNT_W*N_CH-1:0]   pw_out;
  logic [N_CH-1:0]         at_limit;
  logic                    frame_start;
  modport master (output en, dir, load_pw, input servo, pw_out, at_limit, frame_start);
  modport slave  (input en, dir, load_pw, output servo, pw_out, at_limit, frame_start);
endinterface

// File: rtl/pwm_servo_array.sv
// pwm_servo_array: N_CH servo PWM generator sharing one frame timer, per-frame saturating width update.
// Ports: i_clk, i_rst (async active-high), bus (pwm_servo_array_if.slave: en, dir, load_pw in;
// servo, pw_out, at_limit, frame_start out, all registered).
// Option: define PWM_LOAD_SLEW_EN to rate-limit DIR=11 loads to STEP per frame.
module pwm_servo_array #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 16,
  parameter int PRESCALE  = 100,
  parameter int PERIOD_US = 20000,
  parameter int MIN_PW    = 500,
  parameter int MAX_PW    = 2500,
  parameter int STEP      = 10
) (
  input logic               i_clk,
  input logic               i_rst,
  pwm_servo_array_if.slave  bus
);
  localparam int PRE_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int W = CNT_W + 1;
  localparam logic [W-1:0] L_MIN = W'(MIN_PW);
  localparam logic [W-1:0] L_MAX = W'(MAX_PW);
  localparam logic [W-1:0] L_STEP = W'(STEP);
  logic [PRE_W-1:0]             r_pre;
  logic [CNT_W-1:0]             r_frm;
  logic                         r_run;
  logic                         r_fs;
  logic [N_CH-1:0]              r_srv;
  logic [N_CH-1:0]              r_lim;
  logic [N_CH-1:0][CNT_W-1:0]   r_pw;
  logic [N_CH-1:0][CNT_W-1:0]   w_nxt;
  logic [N_CH-1:0]              w_lim;
  logic [N_CH-1:0]              w_srv;
  logic                         w_tick;
  logic                         w_wrap;
  logic [CNT_W-1:0]             w_frm_n;
  assign w_tick  = r_pre == PRE_W'(PRESCALE - 1);
  assign w_wrap  = w_tick && r_frm == CNT_W'(PERIOD_US - 1);
  assign w_frm_n = w_tick ? r_frm + CNT_W'(1) : r_frm;
  // Next-frame width per channel; CNT_W+1 bits so neither limit can wrap.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [W-1:0] w_cur, w_tgt, w_up, w_dn, w_ld, w_sel;
    logic [1:0]   w_cmd;
    always_comb begin
      w_cur = {1'b0, r_pw[g]};
      w_cmd = bus.dir[2*g +: 2];
      w_tgt = {1'b0, bus.load_pw[CNT_W*g +: CNT_W]};
      w_tgt = w_tgt < L_MIN ? L_MIN : w_tgt > L_MAX ? L_MAX : w_tgt;
      w_up  = w_cur + L_STEP > L_MAX ? L_MAX : w_cur + L_STEP;
      w_dn  = w_cur < L_MIN + L_STEP ? L_MIN : w_cur - L_STEP;
`ifdef PWM_LOAD_SLEW_EN
      w_ld  = w_tgt > w_cur ? (w_tgt - w_cur > L_STEP ? w_cur + L_STEP : w_tgt)
                            : (w_cur - w_tgt > L_STEP ? w_cur - L_STEP : w_tgt);
`else
      w_ld  = w_tgt;
`endif
      w_sel = w_cmd == 2'b01 ? w_up : w_cmd == 2'b10 ? w_dn : w_cmd == 2'b11 ? w_ld : w_cur;
    end
    assign w_nxt[g] = w_sel[CNT_W-1:0];
    assign w_lim[g] = w_sel == L_MIN || w_sel == L_MAX;
  end
  // Output level for the cycle after the edge, so SERVO tracks the registered frame counter.
  always_comb begin
    w_srv = '0;
    for (int k = 0; k < N_CH; k++)
      w_srv[k] = !r_run ? r_pw[k] != '0 : w_wrap ? w_nxt[k] != '0 : w_frm_n < r_pw[k];
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_pre <= '0;
      r_frm <= '0;
      r_run <= 1'b0;
      r_fs  <= 1'b0;
      r_srv <= '0;
      r_lim <= '1;
      r_pw  <= {N_CH{CNT_W'(MIN_PW)}};
    end else if (!bus.en) begin
      r_pre <= '0;
      r_frm <= '0;
      r_run <= 1'b0;
      r_fs  <= 1'b0;
      r_srv <= '0;
    end else if (!r_run || w_wrap) begin
      r_pre <= '0;
      r_frm <= '0;
      r_run <= 1'b1;
      r_fs  <= 1'b1;
      r_srv <= w_srv;
      if (r_run) begin
        r_pw  <= w_nxt;
        r_lim <= w_lim;
      end
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      r_frm <= w_frm_n;
      r_fs  <= 1'b0;
      r_srv <= w_srv;
    end
  assign bus.servo       = r_srv;
  assign bus.pw_out      = r_pw;
  assign bus.at_limit    = r_lim;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_pwm_servo_array.sv
// tb_pwm_servo_array: directed stimulus plus a per-cycle frame-level model of the servo array.
module tb_pwm_servo_array;
  localparam int PER = 100, MINP = 5, MAXP = 25, STP = 10;
  logic clk = 0;
  logic rst;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pwm_servo_array_if #(.N_CH(2), .CNT_W(8)) bus ();
  pwm_servo_array #(.N_CH(2), .CNT_W(8), .PRESCALE(1), .PERIOD_US(PER), .MIN_PW(MINP),
                    .MAX_PW(MAXP), .STEP(STP)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask
  function automatic int clampi(input int v);
    return v < MINP ? MINP : v > MAXP ? MAXP : v;
  endfunction
  function automatic int nxt(input int pw, input int cmd, input int ld);
    int t = clampi(ld);
    if (cmd == 1) return clampi(pw + STP);
    if (cmd == 2) return clampi(pw - STP);
`ifdef PWM_LOAD_SLEW_EN
    if (cmd == 3) return t > pw ? (t - pw > STP ? pw + STP : t) : (pw - t > STP ? pw - STP : t);
`else
    if (cmd == 3) return t;
`endif
    return pw;
  endfunction
  // Model: position inside the frame in clocks, and the width each channel holds for this frame.
  int m_pw [2];
  int m_t;
  bit m_run;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_run <= 0;
      m_t <= 0;
      m_pw <= '{MINP, MINP};
    end else if (!bus.en) begin
      m_run <= 0;
      m_t <= 0;
    end else if (!m_run) begin
      m_run <= 1;
      m_t <= 0;
    end else if (m_t == PER - 1) begin
      m_t <= 0;
      for (int c = 0; c < 2; c++)
        m_pw[c] <= nxt(m_pw[c], int'(bus.dir[2*c +: 2]), int'(bus.load_pw[8*c +: 8]));
    end else m_t <= m_t + 1;
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("servo%0d", c), int'(bus.servo[c]), int'(m_run && m_t < m_pw[c]));
      chk($sformatf("pw_out%0d", c), int'(bus.pw_out[8*c +: 8]), m_pw[c]);
      chk($sformatf("at_limit%0d", c), int'(bus.at_limit[c]), int'(m_pw[c] == MINP || m_pw[c] == MAXP));
    end
    chk("frame_start", int'(bus.frame_start), int'(m_run && m_t == 0));
  end
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 300);
    chk("wait_fs", int'(bus.frame_start), 1);
  endtask
  int h0, h1, fsc, cnt;
  int exp_up [4] = '{15, 25, 25, 25};
  int exp_lm [4] = '{0, 1, 1, 1};
  int lds [5] = '{40, 2, 2, 22, 22};
`ifdef PWM_LOAD_SLEW_EN
  int exp_ld [5] = '{25, 15, 5, 15, 22};
`else
  int exp_ld [5] = '{25, 5, 5, 22, 22};
`endif
  initial begin
    rst = 1;
    bus.en = 0;
    bus.dir = '0;
    bus.load_pw = '0;
    repeat (3) @(negedge clk);
    chk("rst_servo", int'(bus.servo), 0);
    chk("rst_pw", int'(bus.pw_out), 16'h0505);
    chk("rst_lim", int'(bus.at_limit), 3);
    chk("rst_fs", int'(bus.frame_start), 0);
    rst = 0;
    bus.en = 1;
    wait_fs();
    h0 = 0; h1 = 0; fsc = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      h0 += int'(bus.servo[0]);
      h1 += int'(bus.servo[1]);
      fsc += int'(bus.frame_start);
      @(negedge clk);
    end
    chk("idle_high0", h0, 10);
    chk("idle_high1", h1, 10);
    chk("idle_fs", fsc, 2);
    chk("idle_fs_now", int'(bus.frame_start), 1);
    bus.dir = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      wait_fs();
      chk("up_pw0", int'(bus.pw_out[7:0]), exp_up[i]);
      chk("up_lim0", int'(bus.at_limit[0]), exp_lm[i]);
      chk("up_pw1", int'(bus.pw_out[15:8]), 5);
    end
    bus.dir = 4'b0110;
    wait_fs();
    chk("opp_pw0", int'(bus.pw_out[7:0]), 15);
    chk("opp_pw1", int'(bus.pw_out[15:8]), 15);
    bus.dir = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      bus.load_pw = {8'd0, 8'(lds[i])};
      wait_fs();
      chk("load_pw0", int'(bus.pw_out[7:0]), exp_ld[i]);
      chk("load_pw1", int'(bus.pw_out[15:8]), 15);
    end
    bus.dir = 4'b0001;
    cnt = 0;
    for (int i = 0; i < PER; i++) begin
      cnt += int'(bus.servo[0]);
      if (i == 50) bus.dir = 4'b0010;
      @(negedge clk);
    end
    chk("mid_pulse", cnt, 22);
    chk("mid_fs", int'(bus.frame_start), 1);
    chk("mid_pw0", int'(bus.pw_out[7:0]), 12);
    bus.dir = 4'b0011;
    bus.load_pw = 16'd40;
    wait_fs();
    chk("pre_rst_pw0", int'(bus.pw_out[7:0]), 25);
    bus.dir = '0;
    repeat (10) @(negedge clk);
    chk("pre_rst_servo0", int'(bus.servo[0]), 1);
    #2 rst = 1;
    #1;
    chk("async_servo", int'(bus.servo), 0);
    chk("async_pw", int'(bus.pw_out), 16'h0505);
    chk("async_fs", int'(bus.frame_start), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_fs", int'(bus.frame_start), 1);
    h0 = 0;
    for (int i = 0; i < PER; i++) begin
      h0 += int'(bus.servo[0]);
      @(negedge clk);
    end
    chk("post_rst_high0", h0, 5);
    bus.dir = 4'b0100;
    wait_fs();
    bus.dir = '0;
    repeat (20) @(negedge clk);
    bus.en = 0;
    @(negedge clk);
    chk("en0_servo", int'(bus.servo), 0);
    chk("en0_fs", int'(bus.frame_start), 0);
    chk("en0_pw1", int'(bus.pw_out[15:8]), 15);
    repeat (5) @(negedge clk);
    bus.en = 1;
    @(negedge clk);
    chk("en1_fs", int'(bus.frame_start), 1);
    chk("en1_servo", int'(bus.servo), 3);
    repeat (30) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_servo_array.md
# pwm_servo_array

Parametrised multi-channel servo PWM generator for the solar tracker, driving N_CH hobby servos (MS60 class) from one shared frame timer. Each channel keeps its own pulse width in microseconds. Once per frame, that width is stepped up, stepped down, held, or loaded from an external target, always saturating at configurable mechanical limits. The block sits between the tracker control FSM (sweep/max-calibration logic) and the servo output pins, and also reports the current pulse width of every channel back to that FSM.

## Interface
- N_CH, 2: number of servo channels.
- CNT_W, 16: width of pulse-width and frame counters in µs; must satisfy 2^CNT_W > PERIOD_US.
- PRESCALE, 100: CLK cycles per µs tick (100 MHz → 1 µs); ≥1.
- PERIOD_US, 20000: frame length in µs.
- MIN_PW, 500: lower pulse-width limit in µs (0°).
- MAX_PW, 2500: upper pulse-width limit in µs (180°); MIN_PW < MAX_PW < PERIOD_US.
- STEP, 10: per-frame increment/decrement in µs.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  run enable; 0 parks all outputs low.
- DIR  in  2*N_CH  per-channel command, channel i at [2i+1:2i]: 00 hold, 01 up (CCW sweep), 10 down, 11 load.
- LOAD_PW  in  CNT_W*N_CH  per-channel target in µs, used when DIR=11.
- SERVO  out  N_CH  PWM outputs, registered.
- PW_OUT  out  CNT_W*N_CH  pulse width in effect for the current frame.
- AT_LIMIT  out  N_CH  1 when the channel's width equals MIN_PW or MAX_PW.
- FRAME_START  out  1  one-cycle pulse on the first clock of every frame.

## Operation
- Prescaler counts 0..PRESCALE-1; its wrap is the µs tick. Frame counter counts ticks 0..PERIOD_US-1, then wraps.
- SERVO[i] = 1 while frame counter < pw[i], else 0. High time is pw[i]*PRESCALE clocks; the frame is PERIOD_US*PRESCALE clocks.
- On the tick that wraps the frame counter, DIR and LOAD_PW are sampled and every pw[i] is updated:
  - 00: pw unchanged.
  - 01: pw = min(pw+STEP, MAX_PW).
  - 10: pw = max(pw-STEP, MIN_PW).
  - 11: pw = LOAD_PW clamped to [MIN_PW, MAX_PW].
- Arithmetic is done in CNT_W+1 bits before clamping, so no wrap-around occurs at either limit.
- DIR/LOAD_PW changes mid-frame have no effect until the next frame boundary. This makes pulses glitch-free; no frame is ever truncated or doubled.
- EN=0: prescaler and frame counter are held at 0, SERVO=0, FRAME_START=0, pw retained (position memory survives a pause).
- EN rising: a new frame starts on the next clock with FRAME_START=1 and the retained pw.
- Channels are fully independent; simultaneous opposite commands on different channels are legal.

## Timing
- Reset values: SERVO=0, FRAME_START=0, every pw=MIN_PW, PW_OUT=MIN_PW per channel, AT_LIMIT all 1, counters 0.
- Reset asserted mid-frame clears everything immediately (asynchronously). The first frame starts on the first EN=1 clock after RST deasserts.
- The pw update, the PW_OUT update, and FRAME_START all occur on the same clock edge. SERVO rises on that edge for every channel with pw>0.
- DIR sampled on frame N's last tick takes effect for frame N+1. Command-to-pulse latency is therefore ≤ 1 frame + 1 clock.
- AT_LIMIT is registered alongside pw with zero extra latency.

## Configuration
- PWM_LOAD_SLEW_EN defined: DIR=11 moves pw toward the clamped LOAD_PW by at most STEP per frame, and stops exactly on target without overshoot. This gives rate-limited return to the max-irradiance position.
- Undefined: DIR=11 jumps to the clamped LOAD_PW in a single frame.

## Test plan
Bench parameters: PRESCALE=1, PERIOD_US=100, MIN_PW=5, MAX_PW=25, STEP=10, N_CH=2.
- Reset then EN=1, DIR=00 → both SERVO high exactly 5 clocks out of every 100; FRAME_START pulses every 100 clocks; AT_LIMIT=11.
- Ch0 DIR=01 for 4 frames → PW_OUT0 = 15, 25, 25, 25; AT_LIMIT[0] rises on the frame where PW_OUT0=25. Ch1 stays at 5.
- Ch0 at 25, DIR=10, and ch1 DIR=01 in the same frame → ch0 = 15, ch1 = 15 on the next FRAME_START.
- DIR=11 with LOAD_PW0=40, then LOAD_PW0=2 → without the macro: 25, then 5. With PWM_LOAD_SLEW_EN from 5 to target 22: 15, then 22.
- DIR toggled 01→10 at clock 50 of a frame → the current pulse is unaffected; only the last-tick value is applied.
- RST pulsed at clock 10 of a frame with pw=25 → SERVO=0 and PW_OUT=5 immediately; the first post-reset pulse is 5 clocks.
